// File: rtl/instr_fetch.sv
// Instruction word fetch buffer. Holds a current word (dc/pc/tkk/valid) and a
// single prefetched word, issuing one outstanding memory read at a time.
// Halves are presented left (tkk=0) then right (tkk=1).
module instr_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        next,
  input  logic        jump,
  input  logic [19:0] jaddr,
  input  logic        jright,
  output logic        mem_req,
  output logic [19:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_data,
  output logic [63:0] dc,
  output logic        tkk,
  output logic        valid,
  output logic [19:0] pc
);

  logic [63:0] dc_q, dc_d;
  logic        tkk_q, tkk_d;
  logic        valid_q, valid_d;
  logic [19:0] pc_q, pc_d;
  logic [63:0] pre_data_q, pre_data_d;
  logic        pre_valid_q, pre_valid_d;
  logic [19:0] faddr_q, faddr_d;
  logic [19:0] mem_addr_q, mem_addr_d;
  logic        busy_q, busy_d;
  logic        drop_q, drop_d;
  // Set by the first jump; reset alone never starts fetching.
  logic        active_q, active_d;

  logic        adv;
  logic        consume;
  logic        ack;
  logic        take;

  // Next-state: jump overrides everything; otherwise advance, accept ack, then
  // issue a new request if the returning word will have a slot to land in.
  always_comb begin
    dc_d        = dc_q;
    tkk_d       = tkk_q;
    valid_d     = valid_q;
    pc_d        = pc_q;
    pre_data_d  = pre_data_q;
    pre_valid_d = pre_valid_q;
    faddr_d     = faddr_q;
    mem_addr_d  = mem_addr_q;
    busy_d      = busy_q;
    drop_d      = drop_q;
    active_d    = active_q;

    adv     = next & valid_q;
    consume = adv & tkk_q;       // right half consumed: the word leaves dc
    ack     = mem_ack & busy_q;
    take    = ack & ~drop_q;

    if (jump) begin
      valid_d     = 1'b0;
      pre_valid_d = 1'b0;
      pc_d        = jaddr;
      tkk_d       = jright;
      active_d    = 1'b1;
      if (busy_q && !mem_ack) begin
        // Stale request still in flight: keep it, discard its data later.
        drop_d  = 1'b1;
        faddr_d = jaddr;
      end else begin
        busy_d     = 1'b1;
        drop_d     = 1'b0;
        mem_addr_d = jaddr;
        faddr_d    = jaddr + 20'd1;
      end
    end else begin
      if (adv) begin
        tkk_d = ~tkk_q;
      end
      if (consume) begin
        pc_d = pc_q + 20'd1;
      end

      if (consume && pre_valid_q) begin
        dc_d        = pre_data_q;
        pre_valid_d = take;
        if (take) begin
          pre_data_d = mem_data;
        end
      end else if (consume || !valid_q) begin
        valid_d = take;
        if (take) begin
          dc_d = mem_data;
        end
      end else if (take) begin
        pre_data_d  = mem_data;
        pre_valid_d = 1'b1;
      end

      if (ack) begin
        busy_d = 1'b0;
        drop_d = 1'b0;
      end

      if (active_q && !busy_d && !(valid_d && pre_valid_d)) begin
        busy_d     = 1'b1;
        mem_addr_d = faddr_q;
        faddr_d    = faddr_q + 20'd1;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      dc_q        <= 64'd0;
      tkk_q       <= 1'b0;
      valid_q     <= 1'b0;
      pc_q        <= 20'd0;
      pre_data_q  <= 64'd0;
      pre_valid_q <= 1'b0;
      faddr_q     <= 20'd0;
      mem_addr_q  <= 20'd0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      dc_q        <= dc_d;
      tkk_q       <= tkk_d;
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      pre_data_q  <= pre_data_d;
      pre_valid_q <= pre_valid_d;
      faddr_q     <= faddr_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
      active_q    <= active_d;
    end
  end

  assign dc       = dc_q;
  assign tkk      = tkk_q;
  assign valid    = valid_q;
  assign pc       = pc_q;
  assign mem_req  = busy_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the fetch buffer.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        next = 1'b0;
  logic        jump = 1'b0;
  logic [19:0] jaddr = 20'd0;
  logic        jright = 1'b0;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_data = 64'd0;
  logic [63:0] dc;
  logic        tkk;
  logic        valid;
  logic [19:0] pc;

  instr_fetch dut (
    .clk      (clk),
    .reset    (reset),
    .next     (next),
    .jump     (jump),
    .jaddr    (jaddr),
    .jright   (jright),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .dc       (dc),
    .tkk      (tkk),
    .valid    (valid),
    .pc       (pc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int age = 0;  // cycles the current request has been waiting

  // Model: words held by the buffer in order, plus fetch bookkeeping.
  logic [63:0] m_q[$];
  logic [63:0] m_dc;
  logic [19:0] m_pc, m_addr, m_faddr;
  logic        m_tkk, m_out, m_drop, m_active;

  function automatic logic [63:0] word(input logic [19:0] a);
    logic [31:0] h;
    h = {12'd0, a} * 32'h9E3779B1;
    return {12'hA5C, a, h};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic jmp, input logic [19:0] ja,
                            input logic jr, input logic nxt, input logic ack,
                            input logic [63:0] data);
    if (rst) begin
      m_q.delete();
      m_dc = 64'd0; m_pc = 20'd0; m_addr = 20'd0; m_faddr = 20'd0;
      m_tkk = 1'b0; m_out = 1'b0; m_drop = 1'b0; m_active = 1'b0;
    end else if (jmp) begin
      m_q.delete();
      m_pc = ja;
      m_tkk = jr;
      m_active = 1'b1;
      if (m_out && !ack) begin
        m_drop = 1'b1;
        m_faddr = ja;
      end else begin
        m_out = 1'b1; m_addr = ja; m_faddr = ja + 20'd1; m_drop = 1'b0;
      end
    end else begin
      if (nxt && m_q.size() > 0) begin
        if (!m_tkk) m_tkk = 1'b1;
        else begin
          m_tkk = 1'b0;
          m_pc = m_pc + 20'd1;
          void'(m_q.pop_front());
        end
      end
      if (ack && m_out) begin
        m_out = 1'b0;
        if (m_drop) m_drop = 1'b0;
        else m_q.push_back(data);
      end
      if (m_active && !m_out && m_q.size() < 2) begin
        m_out = 1'b1; m_addr = m_faddr; m_faddr = m_faddr + 20'd1;
      end
      if (m_q.size() > 0) m_dc = m_q[0];
    end
  endtask

  task automatic compare();
    chk("mem_req", {63'd0, mem_req}, {63'd0, m_out});
    chk("mem_addr", {44'd0, mem_addr}, {44'd0, m_addr});
    chk("valid", {63'd0, valid}, {63'd0, m_q.size() > 0});
    chk("tkk", {63'd0, tkk}, {63'd0, m_tkk});
    chk("pc", {44'd0, pc}, {44'd0, m_pc});
    chk("dc", dc, m_dc);
  endtask

  // One clock: memory acks a request once it has waited lat cycles.
  task automatic step(input logic rst, input logic jmp, input logic [19:0] ja,
                      input logic jr, input logic nxt, input int lat);
    logic a;
    logic req_before;
    a = (mem_req === 1'b1) && (age >= lat);
    req_before = (mem_req === 1'b1);
    reset = rst; jump = jmp; jaddr = ja; jright = jr; next = nxt;
    mem_ack = a;
    mem_data = a ? word(mem_addr) : 64'hDEAD_BEEF_0BAD_F00D;
    model_step(rst, jmp, ja, jr, nxt, a, mem_data);
    @(posedge clk);
    #1;
    if (rst || a) age = 0;
    else if (req_before) age++;
    compare();
  endtask

  task automatic idle(input int lat);
    step(1'b0, 1'b0, 20'd0, 1'b0, 1'b0, lat);
  endtask

  task automatic wait_valid(input string name, input int bound, input int lat);
    int n = 0;
    while (!valid && n < bound) begin
      idle(lat);
      n++;
    end
    chk(name, {63'd0, valid}, 64'd1);
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b0, 20'd0, 1'b0, 1'b0, 1);
    step(1'b1, 1'b0, 20'd0, 1'b0, 1'b0, 1);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_valid", {63'd0, valid}, 64'd0);
    chk("rst_dc", dc, 64'd0);
    idle(1);
    chk("idle_after_rst", {63'd0, mem_req}, 64'd0);

    // Sequential fetch from 0x00100
    step(1'b0, 1'b1, 20'h00100, 1'b0, 1'b0, 1);
    chk("j1_req", {63'd0, mem_req}, 64'd1);
    chk("j1_addr", {44'd0, mem_addr}, 64'h00100);
    wait_valid("j1_wait", 10, 1);
    chk("j1_pc", {44'd0, pc}, 64'h00100);
    chk("j1_tkk", {63'd0, tkk}, 64'd0);
    chk("j1_dc", dc, word(20'h00100));
    step(1'b0, 1'b0, 20'd0, 1'b0, 1'b1, 1);
    chk("j1_tkk1", {63'd0, tkk}, 64'd1);
    step(1'b0, 1'b0, 20'd0, 1'b0, 1'b1, 1);
    wait_valid("j1_wait2", 10, 1);
    chk("j1_pc2", {44'd0, pc}, 64'h00101);
    chk("j1_tkk2", {63'd0, tkk}, 64'd0);
    chk("j1_dc2", dc, word(20'h00101));

    // Jump into the right half
    step(1'b0, 1'b1, 20'h02000, 1'b1, 1'b0, 1);
    wait_valid("j2_wait", 20, 1);
    chk("j2_pc", {44'd0, pc}, 64'h02000);
    chk("j2_tkk", {63'd0, tkk}, 64'd1);
    chk("j2_dc", dc, word(20'h02000));
    step(1'b0, 1'b0, 20'd0, 1'b0, 1'b1, 1);
    wait_valid("j2_wait2", 10, 1);
    chk("j2_pc2", {44'd0, pc}, 64'h02001);
    chk("j2_tkk2", {63'd0, tkk}, 64'd0);

    // Fill, then drain against a slow memory
    repeat (8) idle(1);
    begin
      int n = 0;
      while (valid && n < 20) begin
        step(1'b0, 1'b0, 20'd0, 1'b0, 1'b1, 5);
        n++;
      end
      chk("stall_drop", {63'd0, valid}, 64'd0);
      n = 0;
      while (!valid && n < 20) begin
        step(1'b0, 1'b0, 20'd0, 1'b0, 1'b1, 5);
        n++;
      end
      chk("stall_return", {63'd0, valid}, 64'd1);
      n = 0;
      while (mem_req && n < 10) begin
        idle(0);
        n++;
      end
      chk("quiesce", {63'd0, mem_req}, 64'd0);
    end

    // Jump while a request is outstanding: its data must be discarded
    step(1'b0, 1'b1, 20'h00010, 1'b0, 1'b0, 99);
    chk("j3_addr", {44'd0, mem_addr}, 64'h00010);
    idle(99);
    idle(99);
    step(1'b0, 1'b1, 20'h00040, 1'b0, 1'b0, 99);
    chk("j3_stale_addr", {44'd0, mem_addr}, 64'h00010);
    idle(0);
    chk("j3_dropped", {63'd0, valid}, 64'd0);
    chk("j3_req", {63'd0, mem_req}, 64'd1);
    chk("j3_new_addr", {44'd0, mem_addr}, 64'h00040);
    wait_valid("j3_wait", 10, 1);
    chk("j3_pc", {44'd0, pc}, 64'h00040);
    chk("j3_dc", dc, word(20'h00040));

    // Address wrap
    step(1'b0, 1'b1, 20'hFFFFF, 1'b0, 1'b0, 1);
    wait_valid("wrap_wait", 20, 1);
    chk("wrap_pc", {44'd0, pc}, 64'hFFFFF);
    chk("wrap_dc", dc, word(20'hFFFFF));
    step(1'b0, 1'b0, 20'd0, 1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 20'd0, 1'b0, 1'b1, 1);
    wait_valid("wrap_wait2", 10, 1);
    chk("wrap_pc2", {44'd0, pc}, 64'h00000);
    chk("wrap_dc2", dc, word(20'h00000));

    // Jump + next + ack together, then reset with a request outstanding
    begin
      int n = 0;
      while (!(mem_req && valid) && n < 10) begin
        idle(99);
        n++;
      end
      chk("j4_setup", {63'd0, mem_req && valid}, 64'd1);
    end
    step(1'b0, 1'b1, 20'h00300, 1'b0, 1'b1, 0);
    chk("j4_valid", {63'd0, valid}, 64'd0);
    chk("j4_addr", {44'd0, mem_addr}, 64'h00300);
    chk("j4_pc", {44'd0, pc}, 64'h00300);
    chk("j4_tkk", {63'd0, tkk}, 64'd0);
    step(1'b1, 1'b0, 20'd0, 1'b0, 1'b0, 99);
    chk("r2_req", {63'd0, mem_req}, 64'd0);
    chk("r2_addr", {44'd0, mem_addr}, 64'd0);
    chk("r2_pc", {44'd0, pc}, 64'd0);
    chk("r2_dc", dc, 64'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      logic        r, j, jr, nx;
      logic [19:0] ja;
      int          lat;
      r   = ($urandom_range(0, 299) == 0);
      j   = ($urandom_range(0, 24) == 0);
      jr  = $urandom_range(0, 1) == 1;
      nx  = $urandom_range(0, 9) < 6;
      ja  = $urandom_range(0, 1) == 1 ? 20'($urandom) : 20'hFFFF0 + 20'($urandom_range(0, 15));
      lat = ($urandom_range(0, 9) == 0) ? 6 : $urandom_range(0, 3);
      step(r, j, ja, jr, nx, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
